// File: rtl/seq_divider_param.sv
// Parametrised sequential restoring divider, one quotient bit per clock, signed/unsigned.
// Optional macro SEQ_DIVIDER_EARLY_TERMINATION_EN skips the dividend's leading zeros.
module seq_divider_param #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] leftOperand,
    input  logic [WIDTH-1:0] rightOperand,
    input  logic             isSigned,
    input  logic             activate,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             divisionByZero,
    output logic             overflow
);

    // state  | meaning
    // IDLE   | waiting for activate, results held
    // RUN    | one restoring step per edge
    // FINISH | sign-correct and publish results
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state, stateNext;
    logic [2*WIDTH-1:0] work, workNext;
    logic [WIDTH-1:0]   divisorMag, divisorMagNext;
    logic [WIDTH-1:0]   leftLatched, leftLatchedNext;
    logic               qSign, qSignNext, rSign, rSignNext;
    logic               ovfPending, ovfPendingNext;
    logic [CNT_W-1:0]   counter, counterNext;
    logic               busyNext, doneNext, divisionByZeroNext, overflowNext;
    logic [WIDTH-1:0]   quotientNext, remainderNext;

    logic [WIDTH-1:0]   leftMag, rightMag;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] loadWork;
    logic [CNT_W-1:0]   loadCount;

    // MIN maps to 2^(W-1) here, which the unsigned datapath handles directly.
    assign leftMag  = (isSigned && leftOperand[WIDTH-1])  ? -leftOperand  : leftOperand;
    assign rightMag = (isSigned && rightOperand[WIDTH-1]) ? -rightOperand : rightOperand;
    assign trial    = {1'b0, work[2*WIDTH-2:WIDTH-1]} - {1'b0, divisorMag};

`ifdef SEQ_DIVIDER_EARLY_TERMINATION_EN
    function automatic logic [CNT_W-1:0] countLz(input logic [WIDTH-1:0] value);
        logic [CNT_W-1:0] n;
        n = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) n = CNT_W'(WIDTH - 1 - i);
        end
        return n;
    endfunction

    logic [CNT_W-1:0] leadZeros;
    assign leadZeros = countLz(leftMag);
    assign loadCount = CNT_W'(WIDTH) - leadZeros;
    assign loadWork  = {{WIDTH{1'b0}}, leftMag << leadZeros};
`else
    assign loadCount = CNT_W'(WIDTH);
    assign loadWork  = {{WIDTH{1'b0}}, leftMag};
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            work           <= '0;
            divisorMag     <= '0;
            leftLatched    <= '0;
            qSign          <= 1'b0;
            rSign          <= 1'b0;
            ovfPending     <= 1'b0;
            counter        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            quotient       <= '0;
            remainder      <= '0;
            divisionByZero <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            state          <= stateNext;
            work           <= workNext;
            divisorMag     <= divisorMagNext;
            leftLatched    <= leftLatchedNext;
            qSign          <= qSignNext;
            rSign          <= rSignNext;
            ovfPending     <= ovfPendingNext;
            counter        <= counterNext;
            busy           <= busyNext;
            done           <= doneNext;
            quotient       <= quotientNext;
            remainder      <= remainderNext;
            divisionByZero <= divisionByZeroNext;
            overflow       <= overflowNext;
        end
    end

    always_comb begin
        stateNext          = state;
        workNext           = work;
        divisorMagNext     = divisorMag;
        leftLatchedNext    = leftLatched;
        qSignNext          = qSign;
        rSignNext          = rSign;
        ovfPendingNext     = ovfPending;
        counterNext        = counter;
        busyNext           = busy;
        doneNext           = done;
        quotientNext       = quotient;
        remainderNext      = remainder;
        divisionByZeroNext = divisionByZero;
        overflowNext       = overflow;

        if (activate) begin
            qSignNext       = isSigned & (leftOperand[WIDTH-1] ^ rightOperand[WIDTH-1]);
            rSignNext       = isSigned & leftOperand[WIDTH-1];
            divisorMagNext  = rightMag;
            leftLatchedNext = leftOperand;
            ovfPendingNext  = isSigned && (leftOperand == MIN_VAL) && (rightOperand == '1);
            workNext        = loadWork;
            counterNext     = loadCount;
            busyNext        = 1'b1;
            doneNext        = 1'b0;
            stateNext       = (loadCount == '0) ? FINISH : RUN;
        end else if (cancel) begin
            stateNext = IDLE;
            busyNext  = 1'b0;
            doneNext  = 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (trial[WIDTH])
                        workNext = {work[2*WIDTH-2:0], 1'b0};
                    else
                        workNext = {trial[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
                    counterNext = counter - CNT_W'(1);
                    if (counter <= CNT_W'(1)) stateNext = FINISH;
                end
                FINISH: begin
                    divisionByZeroNext = (divisorMag == '0);
                    overflowNext       = ovfPending;
                    if (divisorMag == '0) begin
                        quotientNext  = '1;
                        remainderNext = leftLatched;
                    end else begin
                        quotientNext  = qSign ? -work[WIDTH-1:0] : work[WIDTH-1:0];
                        remainderNext = rSign ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];
                    end
                    busyNext  = 1'b0;
                    doneNext  = 1'b1;
                    stateNext = IDLE;
                end
                default: ;
            endcase
        end
    end

endmodule
